// File: rtl/ula_multiciclo.sv
// Multi-cycle 74181-style ALU: one 4-bit slice per clock, LSB first, with the
// carry registered between slices. Valid/ready handshakes on both sides.

module ula_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       ci,
  output logic [3:0] f,
  output logic       co,
  output logic       c3
);
  logic [3:0] p, q;
  logic [4:0] sum;

  // Arithmetic is F = P + Q + ci; "-1" rows use Q = all ones.
  always_comb begin
    p = a;
    q = '0;
    unique case (s)
      4'b0000: begin p = a;      q = 4'h0;    end
      4'b0001: begin p = a | b;  q = 4'h0;    end
      4'b0010: begin p = a | ~b; q = 4'h0;    end
      4'b0011: begin p = 4'h0;   q = 4'hF;    end
      4'b0100: begin p = a;      q = a & ~b;  end
      4'b0101: begin p = a | b;  q = a & ~b;  end
      4'b0110: begin p = a;      q = ~b;      end
      4'b0111: begin p = a & ~b; q = 4'hF;    end
      4'b1000: begin p = a;      q = a & b;   end
      4'b1001: begin p = a;      q = b;       end
      4'b1010: begin p = a | ~b; q = a & b;   end
      4'b1011: begin p = a & b;  q = 4'hF;    end
      4'b1100: begin p = a;      q = a;       end
      4'b1101: begin p = a | b;  q = a;       end
      4'b1110: begin p = a | ~b; q = a;       end
      default: begin p = a;      q = 4'hF;    end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {4'b0, ci};

    f  = sum[3:0];
    co = sum[4];
    // Carry into bit 3 recovered from the sum bit; feeds signed overflow.
    c3 = p[3] ^ q[3] ^ sum[3];

    if (m) begin
      co = 1'b0;
      c3 = 1'b0;
      unique case (s)
        4'b0000: f = ~a;
        4'b0001: f = ~(a | b);
        4'b0010: f = ~a & b;
        4'b0011: f = 4'h0;
        4'b0100: f = ~(a & b);
        4'b0101: f = ~b;
        4'b0110: f = a ^ b;
        4'b0111: f = a & ~b;
        4'b1000: f = ~a | b;
        4'b1001: f = ~(a ^ b);
        4'b1010: f = b;
        4'b1011: f = a & b;
        4'b1100: f = 4'hF;
        4'b1101: f = a | ~b;
        4'b1110: f = a | b;
        default: f = a;
      endcase
    end
  end
endmodule

module ula_multiciclo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             a_eq_b
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res, f_nx;
  logic [3:0]       s_r;
  logic             m_r, carry, z_acc, e_acc;
  logic [CW-1:0]    cnt;
  logic [3:0]       sl_f;
  logic             sl_co, sl_c3, sl_z, sl_eq, last;

  // Operands are shifted right each RUN cycle, so the active slice is always [3:0].
  ula_slice u_slice (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .s  (s_r),
    .m  (m_r),
    .ci (carry),
    .f  (sl_f),
    .co (sl_co),
    .c3 (sl_c3)
  );

  assign sl_z  = (sl_f == 4'h0);
  assign sl_eq = (a_sh[3:0] == b_sh[3:0]);
  assign last  = (cnt == CW'(NSLICE - 1));

  // Final result: slices already stored plus the top slice computed this cycle.
  always_comb begin
    f_nx = res;
    f_nx[WIDTH-1 -: 4] = sl_f;
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_r    <= '0;
      m_r    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      z_acc  <= 1'b0;
      e_acc  <= 1'b0;
      f      <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          s_r   <= s;
          m_r   <= m;
          carry <= c_in;
          cnt   <= '0;
          z_acc <= 1'b1;
          e_acc <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          res[{cnt, 2'b00} +: 4] <= sl_f;
          carry <= sl_co;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          z_acc <= z_acc & sl_z;
          e_acc <= e_acc & sl_eq;
          cnt   <= cnt + 1'b1;
          if (last) begin
            f      <= f_nx;
            c_out  <= sl_co;
            ovf    <= sl_c3 ^ sl_co;
            zero   <= z_acc & sl_z;
            a_eq_b <= e_acc & sl_eq;
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Multi-cycle, width-parametrised 74181-style ALU. It accepts one operation through a valid/ready handshake and evaluates it as a chain of 4-bit slices, one slice per clock, LSB first, with the carry registered between slices. The result and status flags are presented through a second valid/ready handshake. It is the scalable successor to the combinational 4-bit ALU and serves datapaths wider than 4 bits where area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
- NSLICE (derived, WIDTH/4), slice count and compute latency in cycles
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- a, b  in  WIDTH  operands, sampled on acceptance
- s  in  4  function select, sampled on acceptance
- m  in  1  mode: 0 = arithmetic, 1 = logic; sampled on acceptance
- c_in  in  1  carry into slice 0, sampled on acceptance
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- f  out  WIDTH  result
- c_out  out  1  carry out of the top slice; 0 in logic mode
- ovf  out  1  signed overflow, (carry into MSB) xor c_out; 0 in logic mode
- zero  out  1  f == 0
- a_eq_b  out  1  a == b over the full width, independent of m and s

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = 1 only in IDLE and only with rst_n high.
- out_valid = 1 only in DONE.
- Acceptance: on in_valid && in_ready, a, b, s, m and c_in are captured, the slice counter is cleared, carry = c_in, and the FSM moves to RUN.
- RUN: each cycle slice k (bits 4k+3:4k) is computed from the captured operands and the registered carry. The slice result is stored and the slice carry-out is registered as the next carry. The a_eq_b and zero accumulators are ANDed with that slice's equality and zero terms.
- RUN ends after slice NSLICE-1. On that edge f, c_out, ovf, zero and a_eq_b load together and the FSM moves to DONE.
- DONE → IDLE on out_ready.
- Arithmetic (m=0): F = P + Q + carry, where P and Q are bitwise terms, "-1" means Q = all ones, and c_out is the true carry of the WIDTH-bit sum. Functions by s:
  - 0000 A; 0001 A|B; 0010 A|~B; 0011 -1 (P = 0)
  - 0100 A+(A&~B); 0101 (A|B)+(A&~B); 0110 A+~B (A-B-1); 0111 (A&~B)-1
  - 1000 A+(A&B); 1001 A+B; 1010 (A|~B)+(A&B); 1011 (A&B)-1
  - 1100 A+A; 1101 (A|B)+A; 1110 (A|~B)+A; 1111 A-1
- Logic (m=1): carry is ignored and c_out = ovf = 0. Functions by s:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A
- Result outputs change only on the RUN→DONE edge. They hold their last value through IDLE, RUN and backpressure.

## Timing
- Reset values: in_ready 0 while rst_n low, then 1 once in IDLE; out_valid 0; f = 0; c_out 0; ovf 0; zero 0; a_eq_b 0; internal counter and carry 0.
- Latency: if acceptance is at edge E0, out_valid rises after edge E_NSLICE (4 cycles for WIDTH=16).
- Throughput: at most one operation per NSLICE+2 cycles. There is no acceptance while an operation is in flight.
- in_valid while in_ready = 0 is ignored. Operand changes after acceptance have no effect.
- out_valid stays high, with outputs stable, until the edge where out_ready is sampled high. in_ready rises the following cycle.
- out_ready while out_valid = 0 is ignored.
- rst_n low in any state, including mid-RUN, aborts the operation immediately. No partial result is ever presented.
- WIDTH=4 degenerates to a single RUN cycle.

## Test plan
- Reset mid-operation: accept, then pull rst_n low on the second RUN cycle → out_valid 0, outputs at reset values, in_ready 1 after release, no result ever issued for the aborted operation.
- Add wrap (WIDTH=16): m=0, s=1001, a=0xFFFF, b=0x0001, c_in=0 → f=0x0000, c_out=1, zero=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract:
  - s=0110, c_in=1, a=b=0x1234 → f=0x0000, c_out=1, zero=1, a_eq_b=1.
  - a=0x8000, b=0x0001, c_in=1 → f=0x7FFF, c_out=1, ovf=1, a_eq_b=0.
- Carry through all slices:
  - s=0000, a=0x0FFF, c_in=1 → f=0x1000, c_out=0.
  - s=0011, c_in=0 → f=0xFFFF, c_out=0.
  - s=0011, c_in=1 → f=0x0000, c_out=1.
- Logic:
  - m=1, s=0110, a=0xF0F0, b=0xFF00 → f=0x0FF0, c_out=0, ovf=0.
  - s=1100 → f=0xFFFF.
  - s=0011 → f=0x0000, zero=1.
- Backpressure: hold out_ready low for 5 cycles in DONE, pulsing in_valid with new operands → out_valid and all outputs stable, in_ready 0, no new acceptance. Raising out_ready → in_ready=1 on the next cycle and the next operation completes correctly.
